// File: rtl/rega_pkg.sv
// Shared types and constants for the multi-zone irrigation controller.
package rega_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        REGANDO = 2'd1,
        ERRO    = 2'd2
    } estado_t;

    localparam logic [1:0] MEF1_REGA = 2'b11;
    localparam logic       MODO_ASP  = 1'b0;
    localparam logic       MODO_GOT  = 1'b1;

endpackage

// File: rtl/rega_multizona_arbitro_rr.sv
// Combinational round-robin search: first valid zone after ultimo, wrapping.
module arbitro_rr #(
    parameter int N_ZONAS = 4
) (
    input  logic [N_ZONAS-1:0]         validas,
    input  logic [$clog2(N_ZONAS)-1:0] ultimo,
    output logic [$clog2(N_ZONAS)-1:0] indice,
    output logic                       algum
);

    localparam int LARG_IDX = $clog2(N_ZONAS);

    logic [LARG_IDX-1:0] cand;

    // Scan from farthest to nearest so the nearest valid zone is the last write.
    always_comb begin
        indice = '0;
        algum  = 1'b0;
        cand   = '0;
        for (int k = N_ZONAS; k >= 1; k--) begin
            cand = LARG_IDX'((int'(ultimo) + k) % N_ZONAS);
            if (validas[cand]) begin
                indice = cand;
                algum  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rega_multizona.sv
// Multi-zone irrigation controller: validates asp/got requests, grants one zone
// at a time round-robin for tempo_rega ticks, and latches zone/global faults.
module rega_multizona
    import rega_pkg::*;
#(
    parameter int N_ZONAS    = 4,
    parameter int LARG_TEMPO = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ZONAS-1:0]         asp,
    input  logic [N_ZONAS-1:0]         got,
    input  logic [1:0]                 mef1,
    input  logic                       limpeza,
    input  logic                       tick,
    input  logic [LARG_TEMPO-1:0]      tempo_rega,
    input  logic                       ack_erro,
    output logic [N_ZONAS-1:0]         valvula_asp,
    output logic [N_ZONAS-1:0]         valvula_got,
    output logic [$clog2(N_ZONAS)-1:0] zona_ativa,
    output logic                       ocupado,
    output logic [N_ZONAS-1:0]         erro_zona,
    output logic                       erro
);

    localparam int                  LARG_IDX = $clog2(N_ZONAS);
    localparam logic [N_ZONAS-1:0]  UM       = N_ZONAS'(1);

    estado_t               estado, estado_n;
    logic [LARG_TEMPO-1:0] contador, contador_n;
    logic [LARG_IDX-1:0]   ultimo, ultimo_n, zona_n, grant;
    logic                  modo, modo_n, algum;
    logic [N_ZONAS-1:0]    conflito, validas, erro_zona_n, vasp_n, vgot_n;
    logic                  pedido, falha, bit_modo, fim;

    assign conflito = asp & got;
    assign pedido   = |(asp | got);
    assign validas  = (asp ^ got) & ~erro_zona & {N_ZONAS{(mef1 == MEF1_REGA) && !limpeza}};
    assign falha    = (limpeza && (pedido || ocupado)) || (pedido && (mef1 != MEF1_REGA));
    assign bit_modo = (modo == MODO_ASP) ? asp[zona_ativa] : got[zona_ativa];
    assign fim      = (tick && (contador <= LARG_TEMPO'(1))) || !bit_modo || conflito[zona_ativa];

    // A flag clears on ack only once its conflict has gone; a live conflict always wins.
    assign erro_zona_n = (erro_zona & ~({N_ZONAS{ack_erro}} & ~conflito)) | conflito;

    arbitro_rr #(.N_ZONAS(N_ZONAS)) u_arbitro (
        .validas (validas),
        .ultimo  (ultimo),
        .indice  (grant),
        .algum   (algum)
    );

    always_comb begin
        estado_n   = estado;
        contador_n = contador;
        ultimo_n   = ultimo;
        modo_n     = modo;
        zona_n     = zona_ativa;
        case (estado)
            OCIOSO: begin
                if (falha) begin
                    estado_n = ERRO;
                end else if (algum) begin
                    estado_n   = REGANDO;
                    zona_n     = grant;
                    contador_n = (tempo_rega == '0) ? LARG_TEMPO'(1) : tempo_rega;
                    modo_n     = asp[grant] ? MODO_ASP : MODO_GOT;
                end
            end
            REGANDO: begin
                if (falha) begin
                    estado_n = ERRO;
                    zona_n   = '0;
                end else if (fim) begin
                    estado_n = OCIOSO;
                    ultimo_n = zona_ativa;
                    zona_n   = '0;
                end else if (tick) begin
                    contador_n = contador - LARG_TEMPO'(1);
                end
            end
            ERRO: begin
                if (ack_erro && !falha) begin
                    estado_n = OCIOSO;
                end
            end
            default: begin
                estado_n = OCIOSO;
                zona_n   = '0;
            end
        endcase
    end

    assign vasp_n = ((estado_n == REGANDO) && (modo_n == MODO_ASP)) ? (UM << zona_n) : '0;
    assign vgot_n = ((estado_n == REGANDO) && (modo_n == MODO_GOT)) ? (UM << zona_n) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            contador    <= '0;
            ultimo      <= LARG_IDX'(N_ZONAS - 1);
            modo        <= MODO_ASP;
            zona_ativa  <= '0;
            valvula_asp <= '0;
            valvula_got <= '0;
            ocupado     <= 1'b0;
            erro_zona   <= '0;
            erro        <= 1'b0;
        end else begin
            estado      <= estado_n;
            contador    <= contador_n;
            ultimo      <= ultimo_n;
            modo        <= modo_n;
            zona_ativa  <= zona_n;
            valvula_asp <= vasp_n;
            valvula_got <= vgot_n;
            ocupado     <= (estado_n == REGANDO);
            erro_zona   <= erro_zona_n;
            erro        <= (|erro_zona_n) || (estado_n == ERRO);
        end
    end

endmodule

// File: tb/tb_rega_multizona.sv
// Scoreboard bench for rega_multizona: each step pushes its expected outputs,
// then pops and compares once the DUT has clocked.
module tb_rega_multizona;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] asp = '0, got = '0;
    logic [1:0] mef1 = 2'b11;
    logic       limpeza = 1'b0, tick = 1'b0, ack_erro = 1'b0;
    logic [7:0] tempo_rega = 8'd1;
    logic [3:0] valvula_asp, valvula_got, erro_zona;
    logic [1:0] zona_ativa;
    logic       ocupado, erro;

    typedef struct packed {
        logic [3:0] va;
        logic [3:0] vg;
        logic [1:0] z;
        logic       oc;
        logic [3:0] ez;
        logic       er;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rega_multizona #(.N_ZONAS(4), .LARG_TEMPO(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .asp         (asp),
        .got         (got),
        .mef1        (mef1),
        .limpeza     (limpeza),
        .tick        (tick),
        .tempo_rega  (tempo_rega),
        .ack_erro    (ack_erro),
        .valvula_asp (valvula_asp),
        .valvula_got (valvula_got),
        .zona_ativa  (zona_ativa),
        .ocupado     (ocupado),
        .erro_zona   (erro_zona),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    function automatic exp_t obs();
        return {valvula_asp, valvula_got, zona_ativa, ocupado, erro_zona, erro};
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("va=%b vg=%b z=%0d oc=%b ez=%b er=%b", x.va, x.vg, x.z, x.oc, x.ez, x.er);
    endfunction

    task automatic aplica(input logic [3:0] a, input logic [3:0] g, input logic [1:0] m,
                          input logic l, input logic t, input logic k, input exp_t e);
        asp = a; got = g; mef1 = m; limpeza = l; tick = t; ack_erro = k;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        asp = '0; got = '0; mef1 = 2'b11; limpeza = 1'b0; tick = 1'b0; ack_erro = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e, o;
        #2 reset = 1'b1;
        #1;
        sb.push_back('0);
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_async: obtido %s, esperado %s", fmt(o), fmt(e)); end
        asp = 4'b0001;
        sb.push_back('0);
        @(posedge clk);
        #1;
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_held: obtido %s, esperado %s", fmt(o), fmt(e)); end
        asp = '0;
        reset = 1'b0;
    endtask

    task automatic test_basico();
        exp_t e, o;
        do_reset();
        tempo_rega = 8'd3;
        for (int c = 0; c <= 12; c++) begin
            e = '0;
            if (c < 11) begin e.va = 4'b0001; e.oc = 1'b1; end
            aplica((c < 12) ? 4'b0001 : 4'b0000, 4'b0000, 2'b11, 1'b0, (c % 4) == 3, 1'b0, e);
            o = obs(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL basico[%0d]: obtido %s, esperado %s", c, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_round_robin();
        exp_t e, o;
        logic [3:0] evg [7] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        logic [1:0] ez  [7] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
        do_reset();
        tempo_rega = 8'd1;
        for (int c = 0; c < 7; c++) begin
            e = '0;
            e.vg = evg[c];
            e.z  = ez[c];
            e.oc = |evg[c];
            aplica(4'b0000, (c < 5) ? 4'b0110 : 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, e);
            o = obs(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL round_robin[%0d]: obtido %s, esperado %s", c, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_conflito();
        exp_t e, o;
        logic [3:0] sa [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic [3:0] sg [8] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic       sk [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] eez[8] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        do_reset();
        tempo_rega = 8'd1;
        for (int c = 0; c < 8; c++) begin
            e = '0;
            e.ez = eez[c];
            e.er = |eez[c];
            if (c == 3) begin e.va = 4'b0100; e.z = 2'd2; e.oc = 1'b1; end
            // Step 4 lands completion (tick, count 1) and conflict on the same edge.
            aplica(sa[c], sg[c], 2'b11, 1'b0, c == 4, sk[c], e);
            o = obs(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL conflito[%0d]: obtido %s, esperado %s", c, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_limpeza();
        exp_t e, o;
        logic [3:0] sa [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001};
        logic       sl [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       sk [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic       eer[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        tempo_rega = 8'd1;
        for (int c = 0; c < 6; c++) begin
            e = '0;
            e.er = eer[c];
            if (c == 0 || c == 5) begin e.va = 4'b0001; e.oc = 1'b1; end
            // Step 1 also carries the final tick: the fault must take precedence.
            aplica(sa[c], 4'b0000, 2'b11, sl[c], c == 1, sk[c], e);
            o = obs(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL limpeza[%0d]: obtido %s, esperado %s", c, fmt(o), fmt(e)); end
        end
        asp = '0;
    endtask

    task automatic test_mef1();
        exp_t e, o;
        do_reset();
        tempo_rega = 8'd2;
        for (int c = 0; c < 4; c++) begin
            e = '0;
            e.er = (c < 2);
            aplica((c < 2) ? 4'b0001 : 4'b0000, 4'b0000, (c < 3) ? 2'b01 : 2'b11, 1'b0, 1'b0, c == 2, e);
            o = obs(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL mef1[%0d]: obtido %s, esperado %s", c, fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_reset_meio();
        exp_t e, o;
        do_reset();
        tempo_rega = 8'd10;
        e = '0; e.va = 4'b0010; e.z = 2'd1; e.oc = 1'b1;
        aplica(4'b0010, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, e);
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_meio_grant: obtido %s, esperado %s", fmt(o), fmt(e)); end
        #2 reset = 1'b1;
        #1;
        sb.push_back('0);
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_meio_async: obtido %s, esperado %s", fmt(o), fmt(e)); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        e = '0; e.va = 4'b0001; e.z = 2'd0; e.oc = 1'b1;
        aplica(4'b0011, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, e);
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_meio_zona0: obtido %s, esperado %s", fmt(o), fmt(e)); end
        e = '0;
        aplica(4'b0000, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, e);
        o = obs(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_err++; $display("FAIL reset_meio_queda: obtido %s, esperado %s", fmt(o), fmt(e)); end
    endtask

    initial begin
        test_reset();
        test_basico();
        test_round_robin();
        test_conflito();
        test_limpeza();
        test_mef1();
        test_reset_meio();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
